// File: rtl/dmem_access_ctrl_if.sv
// Bundle of the pipeline request/response handshake and the data-memory bus
// seen by dmem_access_ctrl.
interface dmem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_sign_mask;
    logic        mem_clk_stall;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_clk_stall, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output mem_addr, mem_wdata, mem_read, mem_write, mem_sign_mask
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_clk_stall, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  mem_addr, mem_wdata, mem_read, mem_write, mem_sign_mask
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store access controller: decodes and checks one MEM-stage request at a
// time, strobes the stalling data memory once and returns a one-cycle response.
module dmem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int DRAIN   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    dmem_access_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_DRAIN     = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_RESP      = 3'd5
    } state_t;

    localparam logic [1:0]  ERR_OK       = 2'b00;
    localparam logic [1:0]  ERR_MISALIGN = 2'b01;
    localparam logic [1:0]  ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0]  ERR_TIMEOUT  = 2'b11;
    localparam logic [15:0] DRAIN_LAST   = 16'(DRAIN - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    // Returns {illegal, sign_mask} for a funct3 in the load or store space.
    function automatic logic [4:0] decode_f3(input logic we, input logic [2:0] f3);
        logic [4:0] r;
        if (we) begin
            case (f3)
                3'b000:  r = {1'b0, 4'b0001};
                3'b001:  r = {1'b0, 4'b0011};
                3'b010:  r = {1'b0, 4'b0111};
                default: r = {1'b1, 4'b0000};
            endcase
        end else begin
            case (f3)
                3'b000:  r = {1'b0, 4'b1001};
                3'b001:  r = {1'b0, 4'b1011};
                3'b010:  r = {1'b0, 4'b0111};
                3'b100:  r = {1'b0, 4'b0001};
                3'b101:  r = {1'b0, 4'b0011};
                default: r = {1'b1, 4'b0000};
            endcase
        end
        return r;
    endfunction

    function automatic logic misaligned_f(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        case (f3[1:0])
            2'b01:   m = a[0];
            2'b10:   m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_err_q, rsp_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [3:0]  mem_sign_mask_q, mem_sign_mask_d;
    logic [4:0]  dec_s;
    logic        mis_s;

    // Next-state and registered-output computation.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        we_d            = we_q;
        rsp_valid_d     = 1'b0;
        rsp_data_d      = rsp_data_q;
        rsp_err_d       = rsp_err_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        mem_sign_mask_d = mem_sign_mask_q;
        dec_s           = decode_f3(bus.req_we, bus.req_funct3);
        mis_s           = misaligned_f(bus.req_funct3, bus.req_addr[1:0]);

        case (state_q)
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d = bus.req_we;
                    if (dec_s[4]) begin
                        state_d    = ST_RESP;
                        rsp_err_d  = ERR_ILLEGAL;
                        rsp_data_d = 32'h0000_0000;
                    end else if (mis_s) begin
                        state_d    = ST_RESP;
                        rsp_err_d  = ERR_MISALIGN;
                        rsp_data_d = 32'h0000_0000;
                    end else begin
                        // Strobe is registered here so it is high for the whole ISSUE cycle.
                        state_d         = ST_ISSUE;
                        mem_addr_d      = bus.req_addr;
                        mem_wdata_d     = bus.req_wdata;
                        mem_sign_mask_d = dec_s[3:0];
                        mem_read_d      = ~bus.req_we;
                        mem_write_d     = bus.req_we;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_ACK;
                cnt_d   = 16'd0;
            end
            ST_WAIT_ACK: begin
                if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_TIMEOUT;
                    rsp_data_d  = 32'h0000_0000;
                end else if (bus.mem_clk_stall) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WAIT_DONE: begin
                // A completion seen on the last allowed cycle wins over the timeout.
                if (!bus.mem_clk_stall) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_OK;
                    rsp_data_d  = we_q ? 32'h0000_0000 : bus.mem_rdata;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_TIMEOUT;
                    rsp_data_d  = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                // Errors arrive here without the pulse; emit it on the following cycle.
                if (rsp_valid_q) begin
                    state_d = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_DRAIN;
                cnt_d   = 16'd0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers, cleared asynchronously into DRAIN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_DRAIN;
            cnt_q           <= 16'd0;
            we_q            <= 1'b0;
            req_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= 32'h0000_0000;
            rsp_err_q       <= ERR_OK;
            mem_addr_q      <= 32'h0000_0000;
            mem_wdata_q     <= 32'h0000_0000;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_sign_mask_q <= 4'b0000;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            we_q            <= we_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_err_q       <= rsp_err_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_sign_mask_q <= mem_sign_mask_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_sign_mask = mem_sign_mask_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table, reset
// sequences and randomized requests against a rule-level reference model.
module tb_dmem_access_ctrl;

    localparam int TMO = 16;
    localparam int DRN = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    dmem_access_ctrl_if bus();

    dmem_access_ctrl #(.TIMEOUT(TMO), .DRAIN(DRN)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Stalling memory model: raises stall the edge it sees a strobe, holds it
    // mem_lat cycles; mem_lat == 0 models a memory that never answers.
    int          mem_lat  = 2;
    logic [31:0] mem_val  = 32'h0;
    int          mem_left = 0;
    logic        stall_r  = 1'b0;
    logic [31:0] rdata_r  = 32'h0;

    assign bus.mem_clk_stall = stall_r;
    assign bus.mem_rdata     = rdata_r;

    always @(posedge clk) begin
        if (mem_left != 0) begin
            if (mem_left == 1) stall_r <= 1'b0;
            mem_left <= mem_left - 1;
        end else if ((bus.mem_read || bus.mem_write) && mem_lat != 0) begin
            stall_r  <= 1'b1;
            mem_left <= mem_lat;
            rdata_r  <= mem_val;
        end
    end

    // {legal, sign mask} for each funct3, straight from the access-type list
    logic [4:0] ld_tbl [8] = '{5'b11001, 5'b11011, 5'b10111, 5'b00000,
                               5'b10001, 5'b10011, 5'b00000, 5'b00000};
    logic [4:0] st_tbl [8] = '{5'b10001, 5'b10011, 5'b10111, 5'b00000,
                               5'b00000, 5'b00000, 5'b00000, 5'b00000};

    function automatic void ref_model(input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr, input int lat,
                                      output logic [1:0] err, output logic [3:0] mask,
                                      output int elat);
        logic [4:0] ent;
        int nbytes;
        ent  = we ? st_tbl[f3] : ld_tbl[f3];
        mask = ent[3:0];
        nbytes = mask[2] ? 4 : (mask[1] ? 2 : 1);
        if (!ent[4]) begin
            err = 2'b10; elat = 1;
        end else if ((addr % 32'(nbytes)) != 32'd0) begin
            err = 2'b01; elat = 1;
        end else if (lat >= 1 && lat <= TMO - 1) begin
            err = 2'b00; elat = lat + 2;
        end else begin
            err = 2'b11; elat = TMO + 1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag, input logic ready_exp);
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(ready_exp));
        chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, ".rsp_data"},  bus.rsp_data, 32'd0);
        chk({tag, ".rsp_err"},   32'(bus.rsp_err), 32'd0);
        chk({tag, ".mem_addr"},  bus.mem_addr, 32'd0);
        chk({tag, ".mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, ".strobes"},   32'({bus.mem_read, bus.mem_write}), 32'd0);
        chk({tag, ".mask"},      32'(bus.mem_sign_mask), 32'd0);
    endtask

    // After reset release ready must stay low for DRN cycles with no response.
    task automatic drain_check(input string tag);
        for (int i = 1; i <= DRN; i++) begin
            @(posedge clk); #1;
            chk($sformatf("%s.drain%0d_ready", tag, i), 32'(bus.req_ready), 32'(i == DRN));
            chk($sformatf("%s.drain%0d_rsp", tag, i), 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input int lat,
                           input logic [31:0] rd, input logic [1:0] e_err,
                           input logic [3:0] e_mask, input int e_lat);
        int waited;
        int got_lat;
        int n_rd;
        int n_wr;
        logic [3:0]  mask_seen;
        logic [31:0] addr_seen;
        logic [31:0] wd_seen;
        logic        legal;
        logic [31:0] e_data;
        legal  = (e_err == 2'b00) || (e_err == 2'b11);
        e_data = (e_err == 2'b00 && !we) ? rd : 32'd0;
        @(negedge clk);
        mem_lat = lat;
        mem_val = rd;
        waited  = 0;
        while (bus.req_ready !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, ".ready_before"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_rd      = int'(bus.mem_read);
        n_wr      = int'(bus.mem_write);
        mask_seen = bus.mem_sign_mask;
        addr_seen = bus.mem_addr;
        wd_seen   = bus.mem_wdata;
        chk({tag, ".ready_after"}, 32'(bus.req_ready), 32'd0);
        got_lat = -1;
        for (int k = 1; k <= 60 && got_lat < 0; k++) begin
            @(posedge clk); #1;
            n_rd += int'(bus.mem_read);
            n_wr += int'(bus.mem_write);
            if (bus.rsp_valid === 1'b1) got_lat = k;
        end
        chk({tag, ".latency"}, 32'(got_lat), 32'(e_lat));
        chk({tag, ".err"},     32'(bus.rsp_err), 32'(e_err));
        chk({tag, ".data"},    bus.rsp_data, e_data);
        chk({tag, ".reads"},   32'(n_rd), 32'((legal && !we) ? 1 : 0));
        chk({tag, ".writes"},  32'(n_wr), 32'((legal && we) ? 1 : 0));
        if (legal) begin
            chk({tag, ".mask"},  32'(mask_seen), 32'(e_mask));
            chk({tag, ".addr"},  addr_seen, addr);
            chk({tag, ".wdata"}, wd_seen, wd);
        end
        @(posedge clk); #1;
        chk({tag, ".pulse_end"},  32'(bus.rsp_valid), 32'd0);
        chk({tag, ".ready_back"}, 32'(bus.req_ready), 32'd1);
        chk({tag, ".err_held"},   32'(bus.rsp_err), 32'(e_err));
        chk({tag, ".data_held"},  bus.rsp_data, e_data);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rd;
        logic [1:0]  err;
        logic [3:0]  mask;
        int          elat;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [1:0]  r_err;
        logic [3:0]  r_mask;
        int          r_lat;
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        int          lat;

        tbl[0]  = '{1'b0, 3'b010, 32'h0000_0004, 32'h0,          2,  32'hDEAD_BEEF, 2'b00, 4'b0111, 4};
        tbl[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,          2,  32'h0000_0080, 2'b00, 4'b1001, 4};
        tbl[2]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,          3,  32'h0000_BEEF, 2'b00, 4'b0011, 5};
        tbl[3]  = '{1'b1, 3'b010, 32'h0000_2000, 32'h0000_00A5,  2,  32'h1111_1111, 2'b00, 4'b0111, 4};
        tbl[4]  = '{1'b0, 3'b010, 32'h0000_0102, 32'h0,          2,  32'h2222_2222, 2'b01, 4'b0000, 1};
        tbl[5]  = '{1'b1, 3'b011, 32'h0000_0000, 32'h5,          2,  32'h0,         2'b10, 4'b0000, 1};
        tbl[6]  = '{1'b0, 3'b011, 32'h0000_0001, 32'h0,          2,  32'h0,         2'b10, 4'b0000, 1};
        tbl[7]  = '{1'b0, 3'b001, 32'h0000_0001, 32'h0,          2,  32'h0,         2'b01, 4'b0000, 1};
        tbl[8]  = '{1'b1, 3'b110, 32'h0000_0003, 32'h0,          2,  32'h0,         2'b10, 4'b0000, 1};
        tbl[9]  = '{1'b1, 3'b001, 32'h0000_0002, 32'h0000_1234,  1,  32'h0,         2'b00, 4'b0011, 3};
        tbl[10] = '{1'b0, 3'b100, 32'h0000_0007, 32'h0,          1,  32'h0000_00FE, 2'b00, 4'b0001, 3};
        tbl[11] = '{1'b0, 3'b010, 32'h0000_0008, 32'h0,          0,  32'h3333_3333, 2'b11, 4'b0111, 17};
        tbl[12] = '{1'b0, 3'b000, 32'h0000_0009, 32'h0,          15, 32'h4444_4444, 2'b00, 4'b1001, 17};
        tbl[13] = '{1'b0, 3'b010, 32'h0000_000C, 32'h0,          16, 32'h5555_5555, 2'b11, 4'b0111, 17};
        tbl[14] = '{1'b1, 3'b000, 32'h0000_2001, 32'h0000_0077,  4,  32'h0,         2'b00, 4'b0001, 6};
        tbl[15] = '{1'b0, 3'b001, 32'h0000_0006, 32'h0,          2,  32'h0000_8001, 2'b00, 4'b1011, 4};

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;

        // Power-on reset and drain window
        repeat (2) @(negedge clk);
        chk_reset_vals("por", 1'b0);
        reset_n = 1'b1;
        drain_check("por");
        chk_reset_vals("por_idle", 1'b1);

        for (int i = 0; i < 16; i++) begin
            run_req($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
                    tbl[i].lat, tbl[i].rd, tbl[i].err, tbl[i].mask, tbl[i].elat);
        end

        // Reset while waiting for the memory to finish a load
        @(negedge clk);
        mem_lat = 6;
        mem_val = 32'hCAFE_F00D;
        chk("midrst.ready_before", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0010;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("midrst.strobe", 32'(bus.mem_read), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst", 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("midrst_hold", 1'b0);
        reset_n = 1'b1;
        drain_check("midrst");
        chk_reset_vals("midrst_idle", 1'b1);

        // Randomized requests against the reference model
        for (int i = 0; i < 40; i++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = $urandom;
            if ($urandom_range(0, 1) == 0) r_addr[1:0] = 2'b00;
            lat = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
            ref_model(r_we, r_f3, r_addr, lat, r_err, r_mask, r_lat);
            run_req($sformatf("rnd%0d", i), r_we, r_f3, r_addr, $urandom, lat, $urandom,
                    r_err, r_mask, r_lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
